// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: transmitter for the 2-bit sequence-detection link.
// Drives a fixed 4-symbol pattern on {o1,o2} with per-symbol hold,
// repeat count, inter-repetition gap, abort and busy/done status.
module seq_pattern_gen #(
  parameter logic [1:0]  SYM0     = 2'b00,
  parameter logic [1:0]  SYM1     = 2'b11,
  parameter logic [1:0]  SYM2     = 2'b00,
  parameter logic [1:0]  SYM3     = 2'b01,
  parameter logic [1:0]  IDLE_SYM = 2'b10,
  parameter int unsigned HOLD     = 1,
  parameter int unsigned GAP      = 0,
  parameter int unsigned REPS_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REPS_W-1:0] reps,
  input  logic              abort,
  output logic              o1,
  output logic              o2,
  output logic              busy,
  output logic              done,
  output logic [1:0]        sym_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Terminal counts for the hold and gap counters (counters run 0..N-1).
  localparam logic [3:0]        HOLD_LAST = 4'(HOLD - 1);
  localparam logic [3:0]        GAP_LAST  = 4'(GAP - 1);
  localparam logic [REPS_W-1:0] REP_ONE   = REPS_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        sym_q, sym_d;
  logic [3:0]        hold_q, hold_d;
  logic [3:0]        gap_q, gap_d;
  logic [REPS_W-1:0] rep_q, rep_d;
  logic [1:0]        pat_q, pat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Symbol table lookup for the pattern position.
  function automatic logic [1:0] sym_lookup(input logic [1:0] idx);
    logic [1:0] s;
    s = SYM0;
    case (idx)
      2'd0: s = SYM0;
      2'd1: s = SYM1;
      2'd2: s = SYM2;
      2'd3: s = SYM3;
      default: s = SYM0;
    endcase
    return s;
  endfunction

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_SEND;
          sym_d   = '0;
          hold_d  = '0;
          gap_d   = '0;
          rep_d   = (reps == '0) ? REP_ONE : reps;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
          sym_d   = '0;
          hold_d  = '0;
          gap_d   = '0;
          rep_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (sym_q != 2'd3) begin
            sym_d = sym_q + 2'd1;
          end else if (rep_q > REP_ONE) begin
            rep_d = rep_q - REP_ONE;
            sym_d = '0;
            if (GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end else begin
            state_d = ST_IDLE;
            sym_d   = '0;
            rep_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
          sym_d   = '0;
          hold_d  = '0;
          gap_d   = '0;
          rep_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_SEND;
          sym_d   = '0;
          hold_d  = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sym_d   = '0;
        hold_d  = '0;
        gap_d   = '0;
        rep_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so that, once registered,
  // they track state_q/sym_q exactly (Moore behaviour, no extra latency).
  always_comb begin
    pat_d  = IDLE_SYM;
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_SEND) begin
      pat_d = sym_lookup(sym_d);
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      pat_q   <= IDLE_SYM;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o1      = pat_q[1];
  assign o2      = pat_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign sym_idx = sym_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: default instance plus a HOLD=2/GAP=1 instance.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [3:0] reps;
  logic       o1, o2, busy, done;
  logic [1:0] sym_idx;

  logic       start2, abort2;
  logic [3:0] reps2;
  logic       p1, p2, busy2, done2;
  logic [1:0] sym_idx2;

  int checks = 0;
  int errors = 0;

  seq_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .reps(reps), .abort(abort),
    .o1(o1), .o2(o2), .busy(busy), .done(done), .sym_idx(sym_idx)
  );

  seq_pattern_gen #(.HOLD(2), .GAP(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .reps(reps2), .abort(abort2),
    .o1(p1), .o2(p2), .busy(busy2), .done(done2), .sym_idx(sym_idx2)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input logic [1:0] s, input logic b,
                                    input logic d, input logic [1:0] i);
    return {s, b, d, i};
  endfunction

  function automatic logic [1:0] pat(input int unsigned k);
    logic [1:0] s;
    case (k % 4)
      0: s = 2'b00;
      1: s = 2'b11;
      2: s = 2'b00;
      default: s = 2'b01;
    endcase
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [5:0] exp);
    chk(tag, {o1, o2, busy, done, sym_idx}, exp);
  endtask

  task automatic chk2(input string tag, input logic [5:0] exp);
    chk(tag, {p1, p2, busy2, done2, sym_idx2}, exp);
  endtask

  logic [1:0] g_sym [17];
  logic [1:0] g_idx [17];

  initial begin
    rst = 1'b1; start = 0; abort = 0; reps = 4'd1;
    start2 = 0; abort2 = 0; reps2 = 4'd2;
    tick(); tick();
    rst = 1'b0;
    chk1("reset", ex(2'b10, 0, 0, 0));
    chk2("reset2", ex(2'b10, 0, 0, 0));

    // abort together with start in IDLE: start ignored
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    chk1("start_abort_idle", ex(2'b10, 0, 0, 0));

    // reps=1
    reps = 4'd1; start = 1; tick(); start = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      chk1($sformatf("r1_s%0d", k), ex(pat(k), 1, 0, 2'(k)));
      tick();
    end
    chk1("r1_done", ex(2'b10, 0, 1, 0));
    tick();
    chk1("r1_after", ex(2'b10, 0, 0, 0));

    // reps=3: 12 back-to-back symbols, single done
    reps = 4'd3; start = 1; tick(); start = 0;
    for (int unsigned k = 0; k < 12; k++) begin
      chk1($sformatf("r3_s%0d", k), ex(pat(k), 1, 0, 2'(k % 4)));
      tick();
    end
    chk1("r3_done", ex(2'b10, 0, 1, 0));
    tick();
    chk1("r3_after", ex(2'b10, 0, 0, 0));

    // reps=0 behaves as reps=1
    reps = 4'd0; start = 1; tick(); start = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      chk1($sformatf("r0_s%0d", k), ex(pat(k), 1, 0, 2'(k)));
      tick();
    end
    chk1("r0_done", ex(2'b10, 0, 1, 0));
    tick();
    chk1("r0_after", ex(2'b10, 0, 0, 0));

    // reps=2 with abort during cycle 3, restart at cycle 5
    reps = 4'd2; start = 1; tick(); start = 0;
    chk1("ab_c1", ex(2'b00, 1, 0, 0)); tick();
    chk1("ab_c2", ex(2'b11, 1, 0, 1)); tick();
    chk1("ab_c3", ex(2'b00, 1, 0, 2));
    abort = 1; tick(); abort = 0;
    chk1("ab_c4", ex(2'b10, 0, 0, 0)); tick();
    chk1("ab_c5", ex(2'b10, 0, 0, 0));
    start = 1; tick(); start = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      chk1($sformatf("ab_re_s%0d", k), ex(pat(k), 1, 0, 2'(k % 4)));
      tick();
    end
    chk1("ab_re_done", ex(2'b10, 0, 1, 0));
    tick();

    // reps=4, start re-pulsed at cycle 2 is ignored; restart in done cycle
    reps = 4'd4; start = 1; tick(); start = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      chk1($sformatf("r4_s%0d", k), ex(pat(k), 1, 0, 2'(k % 4)));
      if (k == 1) start = 1;
      tick();
      start = 0;
    end
    chk1("r4_done", ex(2'b10, 0, 1, 0));
    reps = 4'd1; start = 1; tick(); start = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      chk1($sformatf("b2b_s%0d", k), ex(pat(k), 1, 0, 2'(k)));
      tick();
    end
    chk1("b2b_done", ex(2'b10, 0, 1, 0));
    tick();

    // reps=4, reset asserted during cycle 6
    reps = 4'd4; start = 1; tick(); start = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      chk1($sformatf("rst_s%0d", k), ex(pat(k), 1, 0, 2'(k % 4)));
      if (k < 5) tick();
    end
    rst = 1; tick(); rst = 0;
    chk1("rst_c7", ex(2'b10, 0, 0, 0));
    tick();
    chk1("rst_c8", ex(2'b10, 0, 0, 0));

    // HOLD=2, GAP=1, reps=2 on the second instance
    g_sym = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
              2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01};
    g_idx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0,
              2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    reps2 = 4'd2; start2 = 1; tick(); start2 = 0;
    for (int unsigned k = 0; k < 17; k++) begin
      chk2($sformatf("hg_c%0d", k + 1), ex(g_sym[k], 1, 0, g_idx[k]));
      tick();
    end
    chk2("hg_done", ex(2'b10, 0, 1, 0));
    tick();
    chk2("hg_after", ex(2'b10, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
